// File: rtl/sd_input_pkg.sv
// Shared constants and types for the sigma-delta input conditioning stage.
package sd_input_pkg;

    localparam logic [1:0] IN_MODE_RISE = 2'b00;
    localparam logic [1:0] IN_MODE_FALL = 2'b01;
    localparam logic [1:0] IN_MODE_BOTH = 2'b10;
    localparam logic [1:0] IN_MODE_MAN  = 2'b11;

    localparam int unsigned MAN_MIN_DIV = 8;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } man_state_e;

    // Manchester bit period actually used; small divisors are clamped up.
    function automatic logic [8:0] eff_div(input logic [7:0] div);
        return (div < 8'(MAN_MIN_DIV)) ? 9'(MAN_MIN_DIV) : {1'b0, div};
    endfunction

endpackage

// File: rtl/sd_input_ctrl_man_decoder.sv
// Manchester decoder: tracks mid-bit edges of the synchronised data pin,
// ignores boundary edges and flags a missing mid-bit edge.
module man_decoder
    import sd_input_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       restart_i,
    input  logic [7:0] mandiv_i,
    input  logic       edge_i,
    input  logic       level_i,
    output logic       bit_vld_o,
    output logic       bit_o,
    output logic       err_o
);

    man_state_e state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [8:0] t_eff, t34, t32;

    always_comb begin
        t_eff = eff_div(mandiv_i);
        t34   = t_eff - (t_eff >> 2);
        t32   = t_eff + (t_eff >> 1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ACQ;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_vld_o = 1'b0;
        bit_o     = level_i;
        err_o     = 1'b0;
        if (!en_i || restart_i) begin
            state_d = ACQ;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACQ: begin
                    cnt_d = '0;
                    if (edge_i) begin
                        bit_vld_o = 1'b1;
                        state_d   = TRACK;
                    end
                end
                default: begin
                    // The bit level after a mid-bit edge is the decoded value.
                    if (edge_i && (cnt_q >= t34)) begin
                        bit_vld_o = 1'b1;
                        cnt_d     = '0;
                    end else if (cnt_q >= t32) begin
                        err_o   = 1'b1;
                        state_d = ACQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sd_input_ctrl.sv
// Sigma-delta channel input stage: pin synchronisers, edge/Manchester bit
// recovery, registered strobe outputs and a missing-clock watchdog.
module sd_input_ctrl
    import sd_input_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       SYSCLK,
    input  logic       SYSRST,
    input  logic       sd_d_pin,
    input  logic       sd_c_pin,
    input  logic       reg_inen,
    input  logic [1:0] reg_inmode,
    input  logic [7:0] reg_mandiv,
    input  logic [7:0] reg_ckto,
    input  logic       ckfail_clr,
    output logic       sd_dsd_out,
    output logic       sd_clk_out,
    output logic       ckfail,
    output logic       man_err
);

    localparam int L      = SYNC_STAGES - 1;
    localparam int WU_LEN = SYNC_STAGES + 1;
    localparam int WU_W   = $clog2(WU_LEN + 1);

    logic [SYNC_STAGES-1:0] d_sync_q, c_sync_q;
    logic                   d_hist_q, c_hist_q;
    logic [WU_W-1:0]        wu_q;
    logic                   warm;
    logic                   c_rise_q, c_fall_q, d_edge_q;
    logic                   c_rise_d, c_fall_d, d_edge_d;
    logic [1:0]             mode_q;
    logic                   mode_chg;
    logic                   dec_en, dec_vld, dec_bit, dec_err;
    logic                   bit_evt, bit_val, wd_evt;
    logic                   strobe_d;
    logic                   sd_clk_q, sd_dsd_q, sd_dsd_d, man_err_q;
    logic [7:0]             wdcnt_q, wdcnt_d;
    logic                   ckfail_q, ckfail_d;

    // Edges only count once the chains hold real pin samples, so a pin that
    // is already high at reset release is not mistaken for a transition.
    assign warm     = (wu_q == WU_W'(WU_LEN));
    assign c_rise_d = warm &  c_sync_q[L] & ~c_hist_q;
    assign c_fall_d = warm & ~c_sync_q[L] &  c_hist_q;
    assign d_edge_d = warm & (d_sync_q[L] ^ d_hist_q);
    assign mode_chg = (reg_inmode != mode_q);
    assign dec_en   = reg_inen & (reg_inmode == IN_MODE_MAN);

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            d_sync_q <= '0;
            c_sync_q <= '0;
            d_hist_q <= 1'b0;
            c_hist_q <= 1'b0;
            wu_q     <= '0;
            c_rise_q <= 1'b0;
            c_fall_q <= 1'b0;
            d_edge_q <= 1'b0;
            mode_q   <= IN_MODE_RISE;
        end else begin
            d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], sd_d_pin};
            c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], sd_c_pin};
            d_hist_q <= d_sync_q[L];
            c_hist_q <= c_sync_q[L];
            if (!warm) wu_q <= wu_q + WU_W'(1);
            c_rise_q <= c_rise_d;
            c_fall_q <= c_fall_d;
            d_edge_q <= d_edge_d;
            mode_q   <= reg_inmode;
        end
    end

    man_decoder u_dec (
        .clk_i     (SYSCLK),
        .rst_i     (SYSRST),
        .en_i      (dec_en),
        .restart_i (mode_chg),
        .mandiv_i  (reg_mandiv),
        .edge_i    (d_edge_q),
        .level_i   (d_hist_q),
        .bit_vld_o (dec_vld),
        .bit_o     (dec_bit),
        .err_o     (dec_err)
    );

    always_comb begin
        bit_evt = 1'b0;
        bit_val = d_hist_q;
        wd_evt  = c_rise_q | c_fall_q;
        case (reg_inmode)
            IN_MODE_RISE: bit_evt = c_rise_q;
            IN_MODE_FALL: bit_evt = c_fall_q;
            IN_MODE_BOTH: bit_evt = c_rise_q | c_fall_q;
            default: begin
                bit_evt = dec_vld;
                bit_val = dec_bit;
                wd_evt  = d_edge_q;
            end
        endcase
    end

    always_comb begin
        strobe_d = reg_inen & ~mode_chg & bit_evt;
        sd_dsd_d = strobe_d ? bit_val : sd_dsd_q;

        wdcnt_d = wdcnt_q;
        if (!reg_inen || mode_chg || wd_evt) begin
            wdcnt_d = '0;
        end else if (wdcnt_q != 8'hFF) begin
            wdcnt_d = wdcnt_q + 8'd1;
        end

        // A timeout in the same cycle as a clear keeps the flag set.
        ckfail_d = ckfail_q;
        if (reg_inen) begin
            if ((reg_ckto != 8'd0) && (wdcnt_q == reg_ckto)) begin
                ckfail_d = 1'b1;
            end else if (ckfail_clr) begin
                ckfail_d = 1'b0;
            end
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            sd_clk_q  <= 1'b0;
            sd_dsd_q  <= 1'b0;
            man_err_q <= 1'b0;
            wdcnt_q   <= '0;
            ckfail_q  <= 1'b0;
        end else begin
            sd_clk_q  <= strobe_d;
            sd_dsd_q  <= sd_dsd_d;
            man_err_q <= dec_err;
            wdcnt_q   <= wdcnt_d;
            ckfail_q  <= ckfail_d;
        end
    end

    assign sd_clk_out = sd_clk_q;
    assign sd_dsd_out = sd_dsd_q;
    assign man_err    = man_err_q;
    assign ckfail     = ckfail_q;

endmodule

// File: tb/tb_sd_input_ctrl.sv
// Directed bench for sd_input_ctrl: table of edge-mode vectors plus
// hand-written Manchester, watchdog, warm-up and mode-switch sequences.
module tb_sd_input_ctrl;
    import sd_input_pkg::*;

    logic       SYSCLK = 1'b0;
    logic       SYSRST;
    logic       sd_d_pin, sd_c_pin, reg_inen, ckfail_clr;
    logic [1:0] reg_inmode;
    logic [7:0] reg_mandiv, reg_ckto;
    logic       sd_dsd_out, sd_clk_out, ckfail, man_err;

    always #5 SYSCLK = ~SYSCLK;

    sd_input_ctrl #(.SYNC_STAGES(2)) dut (
        .SYSCLK     (SYSCLK),
        .SYSRST     (SYSRST),
        .sd_d_pin   (sd_d_pin),
        .sd_c_pin   (sd_c_pin),
        .reg_inen   (reg_inen),
        .reg_inmode (reg_inmode),
        .reg_mandiv (reg_mandiv),
        .reg_ckto   (reg_ckto),
        .ckfail_clr (ckfail_clr),
        .sd_dsd_out (sd_dsd_out),
        .sd_clk_out (sd_clk_out),
        .ckfail     (ckfail),
        .man_err    (man_err)
    );

    typedef struct {
        logic [1:0] mode;
        logic       inen;
        int         half;
        int         clk_len;
        logic [7:0] pat;
        int         run_len;
        int         exp_n;
        int         exp_first;
        int         exp_gap;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t        vecs[5];
    int          total = 0;
    int          bad = 0;
    logic [16:0] exp_q[$];
    int          exp_err_t;
    bit          err_seen;

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic observe(input string name, input int t);
        logic [16:0] e;
        logic [15:0] tt;
        tt = 16'(t);
        if (sd_clk_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s extra strobe t=%0d bit=%0b want none", name, t, sd_dsd_out);
            end else begin
                e = exp_q.pop_front();
                if ({tt, sd_dsd_out} != e) begin
                    bad++;
                    $display("FAIL %s strobe got t=%0d bit=%0b want t=%0d bit=%0b",
                             name, t, sd_dsd_out, e[16:1], e[0]);
                end
            end
        end
        if (man_err) begin
            err_seen = 1'b1;
            check({name, " man_err time"}, t, exp_err_t);
        end
    endtask

    task automatic end_scenario(input string name);
        check({name, " missing strobes"}, exp_q.size(), 0);
        if (exp_err_t >= 0) check({name, " man_err seen"}, int'(err_seen), 1);
        exp_q.delete();
    endtask

    task automatic expect_strobe(input int t, input logic b);
        exp_q.push_back({16'(t), b});
    endtask

    task automatic do_reset(input logic c, input logic d, input logic [1:0] mode,
                            input logic inen, input logic [7:0] div, input logic [7:0] ckto);
        SYSRST     = 1'b1;
        sd_c_pin   = c;
        sd_d_pin   = d;
        reg_inmode = mode;
        reg_inen   = inen;
        reg_mandiv = div;
        reg_ckto   = ckto;
        ckfail_clr = 1'b0;
        #1;
        check("rst sd_clk_out", int'(sd_clk_out), 0);
        check("rst sd_dsd_out", int'(sd_dsd_out), 0);
        check("rst ckfail", int'(ckfail), 0);
        check("rst man_err", int'(man_err), 0);
        repeat (2) tick();
        SYSRST    = 1'b0;
        exp_err_t = -1;
        err_seen  = 1'b0;
    endtask

    function automatic logic c_level(input int t, input int half, input int clk_len);
        int u;
        u = (t < clk_len) ? t : clk_len - 1;
        return ((u / half) % 2) == 1;
    endfunction

    function automatic logic qualifies(input logic [1:0] mode, input logic p, input logic c);
        case (mode)
            IN_MODE_RISE: return !p && c;
            IN_MODE_FALL: return p && !c;
            default:      return p != c;
        endcase
    endfunction

    // Data moves to the next pattern bit two cycles after each qualifying edge.
    function automatic logic d_level(input vec_t v, input int t);
        int idx;
        idx = 0;
        for (int u = 1; u <= t - 2; u++) begin
            if (qualifies(v.mode, c_level(u - 1, v.half, v.clk_len), c_level(u, v.half, v.clk_len)))
                idx++;
        end
        return (idx < 8) ? v.pat[idx] : 1'b0;
    endfunction

    function automatic logic man_level(input int t);
        if (t < 30)  return 1'b1;
        if (t < 50)  return 1'b0;
        if (t < 60)  return 1'b1;
        if (t < 70)  return 1'b0;
        if (t < 90)  return 1'b1;
        if (t < 140) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        vec_t  v;
        string nm;

        //            mode          inen half len  pattern       run n  first gap expected bits
        vecs[0] = '{IN_MODE_RISE, 1'b1, 5, 40, 8'b0000_1101, 60, 4,  8, 10, 8'b0000_1101};
        vecs[1] = '{IN_MODE_BOTH, 1'b1, 5, 21, 8'b0000_1101, 45, 4,  8,  5, 8'b0000_1101};
        vecs[2] = '{IN_MODE_FALL, 1'b1, 5, 41, 8'b0000_0110, 60, 4, 13, 10, 8'b0000_0110};
        vecs[3] = '{IN_MODE_BOTH, 1'b1, 3, 13, 8'b0000_0011, 40, 4,  6,  3, 8'b0000_0011};
        vecs[4] = '{IN_MODE_RISE, 1'b0, 5, 40, 8'b0000_1101, 60, 0,  8, 10, 8'b0000_0000};

        for (int i = 0; i < 5; i++) begin
            v  = vecs[i];
            nm = $sformatf("vec%0d", i);
            do_reset(1'b0, d_level(v, 0), v.mode, v.inen, 8'd0, 8'd0);
            for (int k = 0; k < v.exp_n; k++) expect_strobe(v.exp_first + k * v.exp_gap, v.exp_bits[k]);
            for (int t = 0; t < v.run_len; t++) begin
                sd_c_pin = c_level(t, v.half, v.clk_len);
                sd_d_pin = d_level(v, t);
                tick();
                observe(nm, t);
            end
            end_scenario(nm);
        end

        // Manchester bits 0,1,1,0 at T=20, then a long gap and recovery.
        do_reset(1'b0, 1'b1, IN_MODE_MAN, 1'b1, 8'd20, 8'd0);
        expect_strobe(33, 1'b0);
        expect_strobe(53, 1'b1);
        expect_strobe(73, 1'b1);
        expect_strobe(93, 1'b0);
        expect_strobe(143, 1'b1);
        exp_err_t = 124;
        for (int t = 0; t < 150; t++) begin
            sd_c_pin = ((t / 5) % 2) == 1;
            sd_d_pin = man_level(t);
            tick();
            observe("man", t);
        end
        end_scenario("man");

        // Watchdog at 50 cycles with clear coinciding with set, then clear alone.
        do_reset(1'b0, 1'b0, IN_MODE_RISE, 1'b1, 8'd0, 8'd50);
        for (int k = 0; k < 4; k++) expect_strobe(8 + 10 * k, 1'b0);
        for (int t = 0; t < 130; t++) begin
            sd_c_pin   = (t < 40) ? (((t / 5) % 2) == 1) : 1'b1;
            ckfail_clr = (t == 89) || (t == 95);
            tick();
            observe("wdog", t);
            if (t == 88)  check("ckfail before timeout", int'(ckfail), 0);
            if (t == 89)  check("ckfail set wins over clr", int'(ckfail), 1);
            if (t == 94)  check("ckfail sticky", int'(ckfail), 1);
            if (t == 95)  check("ckfail cleared", int'(ckfail), 0);
            if (t == 120) check("ckfail stays clear", int'(ckfail), 0);
        end
        ckfail_clr = 1'b0;
        end_scenario("wdog");

        // Pins high through reset release: nothing until a real edge arrives.
        do_reset(1'b1, 1'b1, IN_MODE_RISE, 1'b1, 8'd0, 8'd0);
        expect_strobe(43, 1'b1);
        for (int t = 0; t < 50; t++) begin
            sd_c_pin = (t < 30) || (t >= 40);
            tick();
            observe("warmup", t);
        end
        end_scenario("warmup");

        // Rise mode to Manchester while a strobe is due; mandiv 0 clamps to 8.
        do_reset(1'b0, 1'b0, IN_MODE_RISE, 1'b1, 8'd0, 8'd0);
        expect_strobe(8, 1'b0);
        expect_strobe(18, 1'b0);
        expect_strobe(43, 1'b1);
        exp_err_t = 56;
        for (int t = 0; t < 60; t++) begin
            sd_c_pin   = ((t / 5) % 2) == 1;
            sd_d_pin   = (t >= 40);
            reg_inmode = (t >= 28) ? IN_MODE_MAN : IN_MODE_RISE;
            tick();
            observe("modesw", t);
            if (t == 28) check("modesw strobe suppressed", int'(sd_clk_out), 0);
        end
        end_scenario("modesw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
